// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational alu between N_REQ requesters.
// One operation is in flight at a time. The operands go out on registered alu_* ports,
// and the result and flags come back as a registered response on a shared bus.

package defs_pkg;
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SLL  = 3'd5,
        ALU_SRL  = 3'd6,
        ALU_PASS = 3'd7
    } alu_opcode_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;
endpackage

// state  | meaning
// S_IDLE | no operation owned; grant the next valid requester in rotation
// S_EXEC | operands sit on the alu; capture its result at the end of this cycle
// S_RESP | response held for the owner until its rsp_ready is seen
module alu_arbiter
    import defs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0]   req_in1,
    input  logic [N_REQ-1:0][WIDTH-1:0]   req_in2,
    input  alu_opcode_t [N_REQ-1:0]       req_op,
    output logic [N_REQ-1:0]              rsp_valid,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [WIDTH-1:0]              rsp_out,
    output alu_flags_t                    rsp_flags,
    output logic [WIDTH-1:0]              alu_in1,
    output logic [WIDTH-1:0]              alu_in2,
    output alu_opcode_t                   alu_op,
    input  logic [WIDTH-1:0]              alu_out,
    input  alu_flags_t                    alu_flags
);
    localparam int IDXW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] grant;
    logic [IDXW-1:0] cand;
    logic [IDXW-1:0] next_ptr;
    logic            grant_found;

    // Find the first valid requester, starting at rr_ptr and wrapping around.
    always_comb begin
        grant       = rr_ptr;
        grant_found = 1'b0;
        cand        = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDXW'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
        next_ptr = (int'(grant) == N_REQ - 1) ? '0 : grant + IDXW'(1);
    end

    // Acceptance is only offered while idle, and only to the winner of the search.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Transaction FSM. The alu operands and the response bus are all registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= '0;
            rsp_out   <= '0;
            rsp_flags <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_op    <= ALU_ADD;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        alu_in1 <= req_in1[grant];
                        alu_in2 <= req_in2[grant];
                        alu_op  <= req_op[grant];
                        owner   <= grant;
                        rr_ptr  <= next_ptr;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_out   <= alu_out;
                    rsp_flags <= alu_flags;
                    rsp_valid <= N_REQ'(1) << owner;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. The bench supplies its own behavioural alu. A
// transaction-level model predicts grants and responses, and a negedge monitor
// checks the DUT against a scoreboard queue.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import defs_pkg::*;

    localparam int WIDTH = 8;
    localparam int N_REQ = 2;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][WIDTH-1:0] req_in1;
    logic [N_REQ-1:0][WIDTH-1:0] req_in2;
    alu_opcode_t [N_REQ-1:0]     req_op;
    logic [N_REQ-1:0]            rsp_valid;
    logic [N_REQ-1:0]            rsp_ready;
    logic [WIDTH-1:0]            rsp_out;
    alu_flags_t                  rsp_flags;
    logic [WIDTH-1:0]            alu_in1, alu_in2, alu_out;
    alu_opcode_t                 alu_op;
    alu_flags_t                  alu_flags;
    logic [WIDTH+3:0]            alu_res;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    alu_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural alu: returns {zero, neg, carry, ovf, result}.
    function automatic logic [WIDTH+3:0] alu_ref(alu_opcode_t op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c, v;
        wide = '0; c = 1'b0; v = 1'b0;
        case (op)
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[WIDTH-1:0]; c = wide[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                r = wide[WIDTH-1:0]; c = wide[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << b[2:0];
            ALU_SRL: r = a >> b[2:0];
            default: r = a;
        endcase
        return {(r == '0), r[WIDTH-1], c, v, r};
    endfunction

    assign alu_res   = alu_ref(alu_op, alu_in1, alu_in2);
    assign alu_out   = alu_res[WIDTH-1:0];
    assign alu_flags = alu_flags_t'(alu_res[WIDTH+3:WIDTH]);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int               owner;
        logic [WIDTH-1:0] res;
        logic [3:0]       flags;
        int               acc_cyc;
    } exp_t;

    typedef struct {
        int               owner;
        logic [WIDTH-1:0] res;
        logic [3:0]       flags;
    } log_t;

    exp_t             sbq[$];
    log_t             rsp_log[$];
    int               grant_log[$];
    int               m_ptr  = 0;
    bit               m_busy = 1'b0;
    logic [WIDTH-1:0] m_in1  = '0;
    logic [WIDTH-1:0] m_in2  = '0;
    alu_opcode_t      m_op   = ALU_ADD;
    logic [N_REQ-1:0] acc_flag = '0;

    // Monitor: predict grants, check the response bus and held alu operands, and
    // record acceptances for the stimulus side.
    always @(negedge clk) begin : mon
        logic [N_REQ-1:0] exp_ready;
        logic [WIDTH+3:0] r;
        exp_t             e;
        bit               found;
        int               idx;
        if (rst) begin
            sbq.delete();
            m_busy   = 1'b0;
            m_ptr    = 0;
            m_in1    = '0;
            m_in2    = '0;
            m_op     = ALU_ADD;
            acc_flag = '0;
        end else begin
            exp_ready = '0;
            found     = 1'b0;
            if (!m_busy) begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = (m_ptr + k) % N_REQ;
                    if (!found && req_valid[idx]) begin
                        exp_ready[idx] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("alu_in1", 32'(alu_in1), 32'(m_in1));
            check("alu_in2", 32'(alu_in2), 32'(m_in2));
            check("alu_op", 32'(alu_op), 32'(m_op));

            if (sbq.size() == 0) begin
                check("rsp_valid_no_txn", 32'(rsp_valid), 32'd0);
            end else begin
                e = sbq[0];
                if (cyc - e.acc_cyc >= 2) begin
                    check("rsp_valid", 32'(rsp_valid), 32'(N_REQ'(1) << e.owner));
                    check("rsp_out", 32'(rsp_out), 32'(e.res));
                    check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                    if (rsp_ready[e.owner]) begin
                        rsp_log.push_back('{owner: e.owner, res: rsp_out, flags: 4'(rsp_flags)});
                        void'(sbq.pop_front());
                        m_busy = 1'b0;
                    end
                end else begin
                    check("rsp_valid_early", 32'(rsp_valid), 32'd0);
                end
            end

            acc_flag = exp_ready & req_valid;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_flag[i]) begin
                    r = alu_ref(req_op[i], req_in1[i], req_in2[i]);
                    sbq.push_back('{owner: i, res: r[WIDTH-1:0], flags: r[WIDTH+3:WIDTH], acc_cyc: cyc});
                    grant_log.push_back(i);
                    m_busy = 1'b1;
                    m_ptr  = (i + 1) % N_REQ;
                    m_in1  = req_in1[i];
                    m_in2  = req_in2[i];
                    m_op   = req_op[i];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(int i, alu_opcode_t op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        req_valid[i] = 1'b1;
        req_op[i]    = op;
        req_in1[i]   = a;
        req_in2[i]   = b;
    endtask

    // Advance until every requester in mask has been accepted once, dropping each valid after acceptance.
    task automatic serve(logic [N_REQ-1:0] mask, int budget);
        logic [N_REQ-1:0] done;
        int n;
        done = '0;
        n = 0;
        while ((done & mask) != mask && n < budget) begin
            tick();
            n++;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc_flag[i] && mask[i]) begin
                    done[i] = 1'b1;
                    req_valid[i] = 1'b0;
                end
            end
        end
        check("serve_timeout", 32'((done & mask) != mask), 32'd0);
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((m_busy || sbq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic check_log(string name, int idx, int owner, logic [WIDTH-1:0] res);
        if (idx < rsp_log.size()) begin
            check({name, "_owner"}, 32'(rsp_log[idx].owner), 32'(owner));
            check({name, "_res"}, 32'(rsp_log[idx].res), 32'(res));
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: response %0d missing, only %0d logged", name, idx, rsp_log.size());
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        int n;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        req_op    = {ALU_ADD, ALU_ADD};
        rsp_ready = '0;
        do_reset();

        // Reset values on the ports.
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_out", 32'(rsp_out), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // Single ADD from requester 0.
        rsp_ready = 2'b11;
        base = rsp_log.size();
        set_req(0, ALU_ADD, 8'h01, 8'h01);
        serve(2'b01, 20);
        wait_idle(20);
        check_log("t1", base, 0, 8'h02);

        // Both requesters valid after reset: 0 first, then 1.
        do_reset();
        base = rsp_log.size();
        set_req(0, ALU_SUB, 8'h05, 8'h03);
        set_req(1, ALU_XOR, 8'hAA, 8'h55);
        serve(2'b11, 40);
        wait_idle(20);
        check_log("t2a", base, 0, 8'h02);
        check_log("t2b", base + 1, 1, 8'hFF);

        // Both held valid for six grants: strict alternation.
        do_reset();
        grant_log.delete();
        set_req(0, ALU_OR, 8'h10, 8'h01);
        set_req(1, ALU_AND, 8'h3C, 8'h0F);
        n = 0;
        while (grant_log.size() < 6 && n < 100) begin
            tick();
            n++;
        end
        req_valid = '0;
        wait_idle(20);
        check("t3_grants", 32'(grant_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check("t3_order", 32'(grant_log[i]), 32'(i % 2));
        end

        // Response backpressure: requester 1 holds off, requester 0 blocked meanwhile.
        base = rsp_log.size();
        rsp_ready = 2'b01;
        set_req(1, ALU_AND, 8'hF0, 8'h0F);
        serve(2'b10, 20);
        set_req(0, ALU_ADD, 8'h03, 8'h04);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("t4_rsp_valid", 32'(rsp_valid), 32'b10);
        check("t4_rsp_out", 32'(rsp_out), 32'h00);
        check("t4_req_ready", 32'(req_ready), 32'd0);
        rsp_ready = 2'b11;
        serve(2'b01, 20);
        wait_idle(20);
        check_log("t4a", base, 1, 8'h00);
        check_log("t4b", base + 1, 0, 8'h07);

        // Reset during EXEC: operation dropped, pointer back to 0.
        set_req(1, ALU_ADD, 8'h07, 8'h08);
        serve(2'b10, 20);
        base = rsp_log.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_rsp_out", 32'(rsp_out), 32'd0);
        check("t5_alu_op", 32'(alu_op), 32'(ALU_ADD));
        check("t5_alu_in1", 32'(alu_in1), 32'd0);
        grant_log.delete();
        set_req(0, ALU_PASS, 8'h5A, 8'h00);
        set_req(1, ALU_PASS, 8'hA5, 8'h00);
        serve(2'b11, 40);
        wait_idle(20);
        check("t5_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
        check_log("t5a", base, 0, 8'h5A);
        check_log("t5b", base + 1, 1, 8'hA5);

        // Shift left: result and flags from the alu.
        base = rsp_log.size();
        set_req(0, ALU_SLL, 8'h01, 8'h01);
        serve(2'b01, 20);
        wait_idle(20);
        check_log("t6", base, 0, 8'h02);
        if (base < rsp_log.size()) begin
            check("t6_flags", 32'(rsp_log[base].flags), 32'h0);
        end

        // Random traffic with random backpressure and occasional withdrawn requests.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || acc_flag[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_op[i]    = alu_opcode_t'(3'($urandom_range(0, 7)));
                    req_in1[i]   = WIDTH'($urandom);
                    req_in2[i]   = WIDTH'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = N_REQ'($urandom);
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        wait_idle(20);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
